// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one single-port memory between the instruction-fetch port and the
// data port. A registered FSM grants one access at a time, returns the
// memory response to its owner as a one-cycle pulse, and counts IDLE cycles
// in which both ports are requesting.
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants on contention.
// Without it the data port always wins contention.
module unified_mem_arbiter #(
    parameter int DATAWIDTH  = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  ARB_Clk_In,
    input  logic                  ARB_Reset_In,
    input  logic                  ARB_Ins_Ready_In,
    input  logic [DATAWIDTH-1:0]  ARB_Ins_Addr_InBUS,
    output logic                  ARB_Ins_Valid_Out,
    output logic [DATAWIDTH-1:0]  ARB_Ins_Readdata_OutBUS,
    input  logic                  ARB_Data_Ready_In,
    input  logic                  ARB_Data_Valid_In,
    input  logic [DATAWIDTH-1:0]  ARB_Data_Addr_InBUS,
    input  logic [DATAWIDTH-1:0]  ARB_Data_Writedata_InBUS,
    input  logic [3:0]            ARB_Data_Byteenable_InBUS,
    output logic                  ARB_Data_Valid_Out,
    output logic                  ARB_Data_Ready_Out,
    output logic [DATAWIDTH-1:0]  ARB_Data_Readdata_OutBUS,
    output logic                  ARB_Mem_Re_Out,
    output logic                  ARB_Mem_We_Out,
    output logic [ADDR_WIDTH-1:0] ARB_Mem_Addr_OutBUS,
    output logic [3:0]            ARB_Mem_Byteenable_OutBUS,
    output logic [DATAWIDTH-1:0]  ARB_Mem_Writedata_OutBUS,
    input  logic [DATAWIDTH-1:0]  ARB_Mem_Readdata_InBUS,
    input  logic                  ARB_Mem_Read_Valid_In,
    input  logic                  ARB_Mem_Write_Ready_In,
    output logic [31:0]           ARB_Conflict_Count_OutBUS
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INS_RD  = 3'd1,
        ST_DATA_RD = 3'd2,
        ST_DATA_WR = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    // last_grant_r encoding: 0 = instruction port, 1 = data port
    localparam logic GRANT_INS  = 1'b0;
    localparam logic GRANT_DATA = 1'b1;

    state_t                state_r;
    logic                  last_grant_r;
    logic                  mem_re_r;
    logic                  mem_we_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [3:0]            mem_be_r;
    logic [DATAWIDTH-1:0]  mem_wd_r;
    logic                  ins_valid_r;
    logic                  data_valid_r;
    logic                  data_ready_r;
    logic [DATAWIDTH-1:0]  ins_rdata_r;
    logic [DATAWIDTH-1:0]  data_rdata_r;
    logic [31:0]           conflict_cnt_r;

    logic ins_req_s;
    logic data_req_s;
    logic contend_s;
    logic grant_data_s;
    logic grant_ins_s;

    // Upper requester address bits are dropped: the memory only sees ADDR_WIDTH bits
    logic unused_addr_bits_s;
    assign unused_addr_bits_s = ^{ARB_Ins_Addr_InBUS[DATAWIDTH-1:ADDR_WIDTH],
                                  ARB_Data_Addr_InBUS[DATAWIDTH-1:ADDR_WIDTH]};

    // Grant decision evaluated from the live request levels while IDLE
    always_comb begin
        ins_req_s    = ARB_Ins_Ready_In;
        data_req_s   = ARB_Data_Ready_In | ARB_Data_Valid_In;
        contend_s    = ins_req_s & data_req_s;
        grant_data_s = 1'b0;
        if (contend_s) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_data_s = (last_grant_r == GRANT_INS);
`else
            grant_data_s = 1'b1;
`endif
        end else begin
            grant_data_s = data_req_s;
        end
        grant_ins_s = ins_req_s & ~grant_data_s;
    end

    // Arbitration FSM with all memory-side and response outputs registered
    always_ff @(posedge ARB_Clk_In) begin
        if (ARB_Reset_In) begin
            state_r        <= ST_IDLE;
            last_grant_r   <= GRANT_INS;
            mem_re_r       <= 1'b0;
            mem_we_r       <= 1'b0;
            mem_addr_r     <= {ADDR_WIDTH{1'b0}};
            mem_be_r       <= 4'b0000;
            mem_wd_r       <= {DATAWIDTH{1'b0}};
            ins_valid_r    <= 1'b0;
            data_valid_r   <= 1'b0;
            data_ready_r   <= 1'b0;
            ins_rdata_r    <= {DATAWIDTH{1'b0}};
            data_rdata_r   <= {DATAWIDTH{1'b0}};
            conflict_cnt_r <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ins_valid_r  <= 1'b0;
                    data_valid_r <= 1'b0;
                    data_ready_r <= 1'b0;
                    if (contend_s && (conflict_cnt_r != 32'hFFFF_FFFF)) begin
                        conflict_cnt_r <= conflict_cnt_r + 32'd1;
                    end
                    if (grant_data_s) begin
                        last_grant_r <= GRANT_DATA;
                        mem_addr_r   <= ARB_Data_Addr_InBUS[ADDR_WIDTH-1:0];
                        mem_be_r     <= ARB_Data_Byteenable_InBUS;
                        // A pending write beats a pending read on the data port
                        if (ARB_Data_Valid_In) begin
                            mem_we_r <= 1'b1;
                            mem_wd_r <= ARB_Data_Writedata_InBUS;
                            state_r  <= ST_DATA_WR;
                        end else begin
                            mem_re_r <= 1'b1;
                            mem_wd_r <= {DATAWIDTH{1'b0}};
                            state_r  <= ST_DATA_RD;
                        end
                    end else if (grant_ins_s) begin
                        last_grant_r <= GRANT_INS;
                        mem_addr_r   <= ARB_Ins_Addr_InBUS[ADDR_WIDTH-1:0];
                        mem_be_r     <= 4'b1111;
                        mem_wd_r     <= {DATAWIDTH{1'b0}};
                        mem_re_r     <= 1'b1;
                        state_r      <= ST_INS_RD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_INS_RD: begin
                    if (ARB_Mem_Read_Valid_In) begin
                        ins_rdata_r <= ARB_Mem_Readdata_InBUS;
                        ins_valid_r <= 1'b1;
                        mem_re_r    <= 1'b0;
                        state_r     <= ST_RESP;
                    end else begin
                        state_r <= ST_INS_RD;
                    end
                end
                ST_DATA_RD: begin
                    if (ARB_Mem_Read_Valid_In) begin
                        data_rdata_r <= ARB_Mem_Readdata_InBUS;
                        data_valid_r <= 1'b1;
                        mem_re_r     <= 1'b0;
                        state_r      <= ST_RESP;
                    end else begin
                        state_r <= ST_DATA_RD;
                    end
                end
                ST_DATA_WR: begin
                    if (ARB_Mem_Write_Ready_In) begin
                        data_ready_r <= 1'b1;
                        mem_we_r     <= 1'b0;
                        state_r      <= ST_RESP;
                    end else begin
                        state_r <= ST_DATA_WR;
                    end
                end
                ST_RESP: begin
                    ins_valid_r  <= 1'b0;
                    data_valid_r <= 1'b0;
                    data_ready_r <= 1'b0;
                    mem_re_r     <= 1'b0;
                    mem_we_r     <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    ins_valid_r  <= 1'b0;
                    data_valid_r <= 1'b0;
                    data_ready_r <= 1'b0;
                    mem_re_r     <= 1'b0;
                    mem_we_r     <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign ARB_Ins_Valid_Out         = ins_valid_r;
    assign ARB_Ins_Readdata_OutBUS   = ins_rdata_r;
    assign ARB_Data_Valid_Out        = data_valid_r;
    assign ARB_Data_Ready_Out        = data_ready_r;
    assign ARB_Data_Readdata_OutBUS  = data_rdata_r;
    assign ARB_Mem_Re_Out            = mem_re_r;
    assign ARB_Mem_We_Out            = mem_we_r;
    assign ARB_Mem_Addr_OutBUS       = mem_addr_r;
    assign ARB_Mem_Byteenable_OutBUS = mem_be_r;
    assign ARB_Mem_Writedata_OutBUS  = mem_wd_r;
    assign ARB_Conflict_Count_OutBUS = conflict_cnt_r;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed testbench for unified_mem_arbiter with a 1-cycle memory model.
// Inputs are driven and outputs sampled on the falling edge of tb_clk_50.
module tb_unified_mem_arbiter;

    logic        tb_clk_50 = 1'b0;
    logic        rst;
    logic        ins_ready;
    logic [31:0] ins_addr;
    logic        ins_valid_o;
    logic [31:0] ins_rdata_o;
    logic        data_ready;
    logic        data_valid;
    logic [31:0] data_addr;
    logic [31:0] data_wd;
    logic [3:0]  data_be;
    logic        data_valid_o;
    logic        data_ready_o;
    logic [31:0] data_rdata_o;
    logic        mem_re;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wd;
    logic [31:0] mem_rdata;
    logic        mem_rd_valid;
    logic        mem_wr_ready;
    logic [31:0] conflict_cnt;
    logic        mem_init;

    logic [31:0] tb_mem [0:1023];

    int tests = 0;
    int fails = 0;

    always #10 tb_clk_50 = ~tb_clk_50;

    unified_mem_arbiter #(.DATAWIDTH(32), .ADDR_WIDTH(10)) dut (
        .ARB_Clk_In                (tb_clk_50),
        .ARB_Reset_In              (rst),
        .ARB_Ins_Ready_In          (ins_ready),
        .ARB_Ins_Addr_InBUS        (ins_addr),
        .ARB_Ins_Valid_Out         (ins_valid_o),
        .ARB_Ins_Readdata_OutBUS   (ins_rdata_o),
        .ARB_Data_Ready_In         (data_ready),
        .ARB_Data_Valid_In         (data_valid),
        .ARB_Data_Addr_InBUS       (data_addr),
        .ARB_Data_Writedata_InBUS  (data_wd),
        .ARB_Data_Byteenable_InBUS (data_be),
        .ARB_Data_Valid_Out        (data_valid_o),
        .ARB_Data_Ready_Out        (data_ready_o),
        .ARB_Data_Readdata_OutBUS  (data_rdata_o),
        .ARB_Mem_Re_Out            (mem_re),
        .ARB_Mem_We_Out            (mem_we),
        .ARB_Mem_Addr_OutBUS       (mem_addr),
        .ARB_Mem_Byteenable_OutBUS (mem_be),
        .ARB_Mem_Writedata_OutBUS  (mem_wd),
        .ARB_Mem_Readdata_InBUS    (mem_rdata),
        .ARB_Mem_Read_Valid_In     (mem_rd_valid),
        .ARB_Mem_Write_Ready_In    (mem_wr_ready),
        .ARB_Conflict_Count_OutBUS (conflict_cnt)
    );

    // 1-cycle memory: answers one cycle after seeing a strobe, byte-lane writes
    always @(posedge tb_clk_50) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) tb_mem[i] <= 32'd0;
            tb_mem[16] <= 32'h00A0_0093;
            mem_rd_valid <= 1'b0;
            mem_wr_ready <= 1'b0;
            mem_rdata    <= 32'd0;
        end else begin
            mem_rd_valid <= mem_re && !mem_rd_valid;
            mem_wr_ready <= mem_we && !mem_wr_ready;
            mem_rdata    <= tb_mem[mem_addr];
            if (mem_we && !mem_wr_ready) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) tb_mem[mem_addr][b*8 +: 8] <= mem_wd[b*8 +: 8];
                end
            end
        end
    end

    task automatic tick();
        @(negedge tb_clk_50);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_data;
        rst        = 1'b1;
        mem_init   = 1'b1;
        ins_ready  = 1'b0;
        ins_addr   = 32'd0;
        data_ready = 1'b0;
        data_valid = 1'b0;
        data_addr  = 32'd0;
        data_wd    = 32'd0;
        data_be    = 4'b0000;
        tick();
        tick();

        // Reset state
        chk("rst_re",     {31'd0, mem_re},       32'd0);
        chk("rst_we",     {31'd0, mem_we},       32'd0);
        chk("rst_addr",   {22'd0, mem_addr},     32'd0);
        chk("rst_be",     {28'd0, mem_be},       32'd0);
        chk("rst_wd",     mem_wd,                32'd0);
        chk("rst_ivalid", {31'd0, ins_valid_o},  32'd0);
        chk("rst_dvalid", {31'd0, data_valid_o}, 32'd0);
        chk("rst_dready", {31'd0, data_ready_o}, 32'd0);
        chk("rst_irdata", ins_rdata_o,           32'd0);
        chk("rst_drdata", data_rdata_o,          32'd0);
        chk("rst_cnt",    conflict_cnt,          32'd0);
        rst      = 1'b0;
        mem_init = 1'b0;
        tick();

        // Instruction fetch from 0x10
        ins_ready = 1'b1;
        ins_addr  = 32'h0000_0010;
        tick();
        chk("ins_c1_re",   {31'd0, mem_re},   32'd1);
        chk("ins_c1_addr", {22'd0, mem_addr}, 32'h010);
        chk("ins_c1_be",   {28'd0, mem_be},   32'hF);
        ins_ready = 1'b0;
        tick();
        chk("ins_c2_valid", {31'd0, ins_valid_o}, 32'd0);
        tick();
        chk("ins_c3_valid", {31'd0, ins_valid_o}, 32'd1);
        chk("ins_c3_rdata", ins_rdata_o,          32'h00A0_0093);
        chk("ins_c3_re",    {31'd0, mem_re},      32'd0);
        chk("ins_c3_dval",  {31'd0, data_valid_o}, 32'd0);
        tick();
        chk("ins_c4_valid", {31'd0, ins_valid_o}, 32'd0);
        chk("ins_c4_hold",  ins_rdata_o,          32'h00A0_0093);

        // Partial store to 0x20 then readback
        data_valid = 1'b1;
        data_addr  = 32'h0000_0020;
        data_wd    = 32'hDEAD_BEEF;
        data_be    = 4'b0011;
        tick();
        chk("wr_c1_we",   {31'd0, mem_we},   32'd1);
        chk("wr_c1_re",   {31'd0, mem_re},   32'd0);
        chk("wr_c1_addr", {22'd0, mem_addr}, 32'h020);
        chk("wr_c1_wd",   mem_wd,            32'hDEAD_BEEF);
        chk("wr_c1_be",   {28'd0, mem_be},   32'h3);
        tick();
        tick();
        chk("wr_c3_ready", {31'd0, data_ready_o}, 32'd1);
        data_valid = 1'b0;
        tick();
        chk("wr_c4_ready", {31'd0, data_ready_o}, 32'd0);
        data_ready = 1'b1;
        data_be    = 4'b1111;
        tick();
        chk("rb_c1_re",   {31'd0, mem_re},   32'd1);
        chk("rb_c1_addr", {22'd0, mem_addr}, 32'h020);
        data_ready = 1'b0;
        tick();
        tick();
        chk("rb_c3_valid", {31'd0, data_valid_o}, 32'd1);
        chk("rb_c3_rdata", data_rdata_o,          32'h0000_BEEF);
        tick();
        chk("rb_c4_valid", {31'd0, data_valid_o}, 32'd0);

        // Write and read requested together: write first, then read
        data_valid = 1'b1;
        data_ready = 1'b1;
        data_addr  = 32'h0000_0030;
        data_wd    = 32'h1234_5678;
        data_be    = 4'b1111;
        tick();
        chk("wr_rd_c1_we", {31'd0, mem_we}, 32'd1);
        chk("wr_rd_c1_re", {31'd0, mem_re}, 32'd0);
        tick();
        tick();
        chk("wr_rd_c3_ready", {31'd0, data_ready_o}, 32'd1);
        chk("wr_rd_c3_dval",  {31'd0, data_valid_o}, 32'd0);
        data_valid = 1'b0;
        tick();
        chk("wr_rd_c4_ready", {31'd0, data_ready_o}, 32'd0);
        tick();
        chk("wr_rd_c5_re", {31'd0, mem_re}, 32'd1);
        chk("wr_rd_c5_we", {31'd0, mem_we}, 32'd0);
        data_ready = 1'b0;
        tick();
        tick();
        chk("wr_rd_c7_dval",  {31'd0, data_valid_o}, 32'd1);
        chk("wr_rd_c7_rdata", data_rdata_o,          32'h1234_5678);
        chk("wr_rd_c7_ready", {31'd0, data_ready_o}, 32'd0);
        tick();
        chk("wr_rd_c8_dval", {31'd0, data_valid_o}, 32'd0);

        // Reset during DATA_RD in the cycle the memory answers
        data_ready = 1'b1;
        data_addr  = 32'h0000_0020;
        tick();
        chk("rstmid_c1_re", {31'd0, mem_re}, 32'd1);
        data_ready = 1'b0;
        tick();
        chk("rstmid_c2_memvalid", {31'd0, mem_rd_valid}, 32'd1);
        rst = 1'b1;
        tick();
        chk("rstmid_dval",   {31'd0, data_valid_o}, 32'd0);
        chk("rstmid_re",     {31'd0, mem_re},       32'd0);
        chk("rstmid_addr",   {22'd0, mem_addr},     32'd0);
        chk("rstmid_drdata", data_rdata_o,          32'd0);
        chk("rstmid_irdata", ins_rdata_o,           32'd0);
        rst = 1'b0;
        tick();
        chk("rstmid_after_dval", {31'd0, data_valid_o}, 32'd0);
        chk("rstmid_after_re",   {31'd0, mem_re},       32'd0);

        // Continuous contention for 8 grants
        ins_ready  = 1'b1;
        ins_addr   = 32'h0000_0010;
        data_ready = 1'b1;
        data_addr  = 32'h0000_0020;
        data_be    = 4'b1111;
        for (int g = 0; g < 8; g++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_data = ((g % 2) == 0);
`else
            exp_data = 1'b1;
`endif
            tick();
            chk($sformatf("cont_g%0d_re", g),   {31'd0, mem_re}, 32'd1);
            chk($sformatf("cont_g%0d_addr", g), {22'd0, mem_addr}, exp_data ? 32'h020 : 32'h010);
            chk($sformatf("cont_g%0d_cnt", g),  conflict_cnt, g + 1);
            if (g == 7) begin
                ins_ready  = 1'b0;
                data_ready = 1'b0;
            end
            tick();
            tick();
            chk($sformatf("cont_g%0d_ival", g), {31'd0, ins_valid_o},  exp_data ? 32'd0 : 32'd1);
            chk($sformatf("cont_g%0d_dval", g), {31'd0, data_valid_o}, exp_data ? 32'd1 : 32'd0);
            tick();
        end
        tick();
        chk("cont_cnt_final", conflict_cnt, 32'd8);
        chk("cont_drdata",    data_rdata_o, 32'h0000_BEEF);

        // Counter saturation from a preloaded value
        force dut.conflict_cnt_r = 32'hFFFF_FFFE;
        #2;
        release dut.conflict_cnt_r;
        chk("sat_preload", conflict_cnt, 32'hFFFF_FFFE);
        ins_ready  = 1'b1;
        data_ready = 1'b1;
        for (int g = 0; g < 3; g++) begin
            tick();
            chk($sformatf("sat_g%0d_cnt", g), conflict_cnt, 32'hFFFF_FFFF);
            if (g == 2) begin
                ins_ready  = 1'b0;
                data_ready = 1'b0;
            end
            tick();
            tick();
            tick();
        end
        tick();
        chk("sat_final", conflict_cnt, 32'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
